clint_axi_master: RTL

- Single-outstanding AXI4 master that turns a simple command/response interface into single-beat 64-bit AXI reads and writes.
- Its target is the CLINT slave port (msip, mtimecmp, mtime) and similar register slaves in the same subsystem.
- Intended users are a host bridge or debug sequencer that must program timer/IPI registers without speaking AXI.
- Exactly one transaction is in flight at any time.

---
 rtl/clint_axi_master_if.sv | 82 ++++++++
 rtl/clint_axi_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clint_axi_master_if.sv
// rtl/clint_axi_master_if.sv - AXI4 bus bundle between the CLINT command master and its register slave
interface clint_axi_master_if #(
    parameter int AXI_ID_WIDTH = 5
);
    logic [AXI_ID_WIDTH-1:0] axi_awid;
    logic [63:0]             axi_awaddr;
    logic [7:0]              axi_awlen;
    logic [2:0]              axi_awsize;
    logic [1:0]              axi_awburst;
    logic [2:0]              axi_awprot;
    logic                    axi_awvalid;
    logic                    axi_awready;
    logic                    axi_awlock;
    logic [3:0]              axi_awcache;
    logic [3:0]              axi_awregion;
    logic [3:0]              axi_awuser;
    logic [3:0]              axi_awqos;
    logic [5:0]              axi_awatop;

    logic [63:0]             axi_wdata;
    logic [7:0]              axi_wstrb;
    logic                    axi_wlast;
    logic                    axi_wvalid;
    logic                    axi_wready;
    logic [3:0]              axi_wuser;

    logic [AXI_ID_WIDTH-1:0] axi_bid;
    logic [1:0]              axi_bresp;
    logic                    axi_bvalid;
    logic                    axi_bready;

    logic [AXI_ID_WIDTH-1:0] axi_arid;
    logic [63:0]             axi_araddr;
    logic [7:0]              axi_arlen;
    logic [2:0]              axi_arsize;
    logic [1:0]              axi_arburst;
    logic [2:0]              axi_arprot;
    logic                    axi_arvalid;
    logic                    axi_arready;
    logic                    axi_arlock;
    logic [3:0]              axi_arcache;
    logic [3:0]              axi_arregion;
    logic [3:0]              axi_aruser;
    logic [3:0]              axi_arqos;

    logic [AXI_ID_WIDTH-1:0] axi_rid;
    logic [63:0]             axi_rdata;
    logic [1:0]              axi_rresp;
    logic                    axi_rlast;
    logic                    axi_rvalid;
    logic                    axi_rready;

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awprot, axi_awvalid,
        output axi_awlock, axi_awcache, axi_awregion, axi_awuser, axi_awqos, axi_awatop,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_wuser,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arprot, axi_arvalid,
        output axi_arlock, axi_arcache, axi_arregion, axi_aruser, axi_arqos,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready
    );

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awprot, axi_awvalid,
        input  axi_awlock, axi_awcache, axi_awregion, axi_awuser, axi_awqos, axi_awatop,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_wuser,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arprot, axi_arvalid,
        input  axi_arlock, axi_arcache, axi_arregion, axi_aruser, axi_arqos,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready
    );
endinterface

// File: rtl/clint_axi_master.sv
// rtl/clint_axi_master.sv - single-outstanding command/response to single-beat 64-bit AXI4 master
module clint_axi_master #(
    parameter int AXI_ID_WIDTH = 5,
    parameter int AXI_ID       = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [63:0]         cmd_addr_i,
    input  logic [63:0]         cmd_wdata_i,
    input  logic [7:0]          cmd_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [63:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    clint_axi_master_if.master  axi
);

    localparam logic [AXI_ID_WIDTH-1:0] ID_C = AXI_ID_WIDTH'(AXI_ID);
    localparam logic [1:0]              RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [60:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  be_q, be_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        bready_q, bready_d;
    logic        rready_q, rready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        aw_done, w_done;

    // The low address bits select a byte lane only; the bus access is always 8-byte aligned.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^cmd_addr_i[2:0];

    // Next-state and next-output computation; every AXI-facing output comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        aw_done     = !awvalid_q || axi.axi_awready;
        w_done      = !wvalid_q  || axi.axi_wready;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    addr_d  = cmd_addr_i[63:3];
                    wdata_d = cmd_wdata_i;
                    be_d    = cmd_be_i;
                    if (cmd_we_i) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // AW and W complete independently; either order or the same cycle is fine.
                if (aw_done) awvalid_d = 1'b0;
                if (w_done)  wvalid_d  = 1'b0;
                if (aw_done && w_done) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (axi.axi_bvalid && bready_q) begin
                    rdata_d     = 64'd0;
                    err_d       = (axi.axi_bresp != RESP_OKAY) || (axi.axi_bid != ID_C);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RD_ADDR: begin
                if (axi.axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.axi_rvalid && rready_q) begin
                    rdata_d     = axi.axi_rdata;
                    err_d       = (axi.axi_rresp != RESP_OKAY) || (axi.axi_rid != ID_C) ||
                                  !axi.axi_rlast;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bready_d    = (state_d == WR_RESP);
        rready_d    = (state_d == RD_DATA);
        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign axi.axi_awid     = ID_C;
    assign axi.axi_awaddr   = {addr_q, 3'b000};
    assign axi.axi_awlen    = 8'd0;
    assign axi.axi_awsize   = 3'd3;
    assign axi.axi_awburst  = 2'b01;
    assign axi.axi_awprot   = 3'd0;
    assign axi.axi_awvalid  = awvalid_q;
    assign axi.axi_awlock   = 1'b0;
    assign axi.axi_awcache  = 4'd0;
    assign axi.axi_awregion = 4'd0;
    assign axi.axi_awuser   = 4'd0;
    assign axi.axi_awqos    = 4'd0;
    assign axi.axi_awatop   = 6'd0;

    assign axi.axi_wdata    = wdata_q;
    assign axi.axi_wstrb    = be_q;
    assign axi.axi_wlast    = 1'b1;
    assign axi.axi_wvalid   = wvalid_q;
    assign axi.axi_wuser    = 4'd0;

    assign axi.axi_bready   = bready_q;

    assign axi.axi_arid     = ID_C;
    assign axi.axi_araddr   = {addr_q, 3'b000};
    assign axi.axi_arlen    = 8'd0;
    assign axi.axi_arsize   = 3'd3;
    assign axi.axi_arburst  = 2'b01;
    assign axi.axi_arprot   = 3'd0;
    assign axi.axi_arvalid  = arvalid_q;
    assign axi.axi_arlock   = 1'b0;
    assign axi.axi_arcache  = 4'd0;
    assign axi.axi_arregion = 4'd0;
    assign axi.axi_aruser   = 4'd0;
    assign axi.axi_arqos    = 4'd0;

    assign axi.axi_rready   = rready_q;

endmodule
